// File: rtl/ppa_pkg.sv
// Shared types and helpers for the peripheral port arbiter and its round-robin picker.
// Holds the FSM state encoding, the index-width helper and the default stall timeout.
package ppa_pkg;

  typedef enum logic {
    PPA_IDLE = 1'b0,
    PPA_BUSY = 1'b1
  } ppa_state_t;

  localparam int PPA_TIMEOUT_DEF = 255;

  // A one-bit index is kept even for two requesters so no port collapses to zero width.
  function automatic int ppa_idx_w(input int num_req);
    return (num_req > 2) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/periph_port_arbiter_rr_pick.sv
// Combinational rotate-priority picker: first set request at or above ptr, wrapping modulo N.
// Zero latency; no flow control, purely a function of req and ptr.
module rr_pick
  import ppa_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = ppa_idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] idx,
  output logic          found
);

  logic [IW:0]   sum;
  logic [IW-1:0] cand;

  // ptr is always below N, so a single conditional subtract performs the wrap.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int i = 0; i < N; i++) begin
      sum = {1'b0, ptr} + (IW+1)'(i);
      if (sum >= (IW+1)'(N)) begin
        sum = sum - (IW+1)'(N);
      end
      cand = sum[IW-1:0];
      if (!found && req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/periph_port_arbiter.sv
// Round-robin burst arbiter sharing one peripheral write port; grant one cycle after request, burst held to last.
// Optional stall timeout revokes a grant (build with PPA_TIMEOUT_EN); tgt_ready feeds req_ready combinationally.
module periph_port_arbiter
  import ppa_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = PPA_TIMEOUT_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_last,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]         tgt_data,
  output logic                      tgt_write_enable,
  input  logic                      tgt_ready,
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      busy,
  output logic                      timeout_err
);

  localparam int IW = ppa_idx_w(NUM_REQ);

  ppa_state_t    state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] gnt_idx;
  logic [IW-1:0] pick_idx;
  logic [IW-1:0] ptr_next;
  logic          pick_found;
  logic          act;
  logic          xfer;
  logic          release_burst;
  logic          revoke;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .req   (req_valid),
    .ptr   (ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign busy = (state == PPA_BUSY);

  // Reset gates the port so no beat can be accepted in the reset cycle itself.
  assign act              = busy && !rst;
  assign tgt_write_enable = act && req_valid[gnt_idx];
  assign tgt_data         = act ? req_data[int'(gnt_idx)*DATA_W +: DATA_W] : '0;
  assign xfer             = tgt_write_enable && tgt_ready;
  assign release_burst    = xfer && req_last[gnt_idx];
  assign ptr_next         = (gnt_idx == IW'(NUM_REQ-1)) ? '0 : gnt_idx + IW'(1);

  always_comb begin
    req_ready          = '0;
    req_ready[gnt_idx] = act && tgt_ready;
  end

`ifdef PPA_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT+1);

  logic [CW-1:0] stall_cnt;

  // A transfer in the expiry cycle wins, so the stall is only judged without xfer.
  assign revoke = busy && !xfer && (stall_cnt == CW'(TIMEOUT-1));

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt   <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= revoke;
      if (!busy || xfer || revoke) begin
        stall_cnt <= '0;
      end else begin
        stall_cnt <= stall_cnt + CW'(1);
      end
    end
  end
`else
  assign revoke      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= PPA_IDLE;
      ptr     <= '0;
      gnt_idx <= '0;
      gnt     <= '0;
    end else begin
      case (state)
        PPA_IDLE: begin
          if (pick_found) begin
            state   <= PPA_BUSY;
            gnt_idx <= pick_idx;
            gnt     <= NUM_REQ'(1) << pick_idx;
          end
        end
        PPA_BUSY: begin
          if (release_burst || revoke) begin
            state <= PPA_IDLE;
            gnt   <= '0;
            ptr   <= ptr_next;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/periph_port_arbiter.md
# periph_port_arbiter

Round-robin arbiter that shares one peripheral write port (the UART or GPIO data/write-enable path fed by the NoC) among `NUM_REQ` requesters. Each requester presents valid/ready beats with a `last` marker. The arbiter grants one requester at a time and holds the grant until that requester's burst completes, so bursts are never interleaved. It sits between the NoC request sources and a single peripheral slave and runs in that peripheral's clock domain.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, 2..8.
- `DATA_W`, 32: beat data width.
- `TIMEOUT`, 255: stall cycles before a grant is revoked. Used only with `PPA_TIMEOUT_EN`. Must be ≥ 1.

Ports:
- `clk`  in  1: single clock. Everything is on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req_valid`  in  NUM_REQ: per-requester beat valid.
- `req_last`  in  NUM_REQ: per-requester final-beat marker, qualified by valid.
- `req_data`  in  NUM_REQ*DATA_W: packed beat data; requester i occupies bits [i*DATA_W +: DATA_W].
- `req_ready`  out  NUM_REQ: per-requester beat accepted.
- `tgt_data`  out  DATA_W: data to the peripheral.
- `tgt_write_enable`  out  1: beat valid to the peripheral.
- `tgt_ready`  in  1: peripheral accepts the beat.
- `gnt`  out  NUM_REQ: one-hot current grant.
- `busy`  out  1: a grant is held.
- `timeout_err`  out  1: one-cycle pulse when a grant is revoked. Tied to 0 without the macro.

## Operation
- The state machine has two states, IDLE and BUSY. Reset puts it in IDLE with round-robin pointer `ptr` = 0.
- IDLE:
  - If any `req_valid` is set, pick the first set index searching upward from `ptr`, wrapping modulo NUM_REQ.
  - Register that index into `gnt_idx` and set `gnt` one-hot.
  - Go to BUSY.
  - With no valid request, stay in IDLE.
- BUSY outputs:
  - `tgt_write_enable = req_valid[gnt_idx]`
  - `tgt_data = req_data[gnt_idx]`
  - `req_ready[gnt_idx] = tgt_ready`; all other `req_ready` bits are 0.
  - These are combinational muxes from the registered `gnt_idx`.
- Transfer rule: a beat transfers when `tgt_write_enable && tgt_ready` in BUSY.
- Release: when the transferring beat has `req_last[gnt_idx]=1`, go to IDLE, clear `gnt`, and set `ptr = (gnt_idx+1) mod NUM_REQ`.
- Single-beat bursts: a transfer with last=1 on the first BUSY cycle is legal.
- A granted requester may drop valid mid-burst. The grant is held and other requesters wait.
- Requests seen while BUSY are not acted on until the next IDLE cycle.
- In IDLE, all `req_ready` bits are 0 and `tgt_write_enable` is 0.
- Reset mid-burst: on the next edge everything returns to reset values and the partial burst is abandoned. No beat transfers in the reset cycle.
- Reset values:
  - `gnt` = 0, `busy` = 0, `timeout_err` = 0.
  - `req_ready` = 0, `tgt_write_enable` = 0, `tgt_data` = 0.
  - `tgt_data` is forced to 0 whenever not BUSY.

## Timing
- Arbitration latency: a request asserted in IDLE at cycle N has `gnt`/`busy` high at cycle N+1. Its first beat can transfer at N+1.
- Back-to-back bursts always have exactly one IDLE cycle between release and the next grant.
- Throughput inside a burst is one beat per cycle while `tgt_ready=1`.
- The `req_*` to `tgt_*` and `tgt_ready` to `req_ready` paths are combinational. No data register is added.
- The arbitration pick is combinational from `req_valid` and `ptr` and is registered into `gnt_idx`.

## Configuration
- `PPA_TIMEOUT_EN` defined:
  - A stall counter of width $clog2(TIMEOUT+1) clears on grant and on every transfer.
  - It increments each BUSY cycle without a transfer.
  - When it reaches TIMEOUT, the arbiter goes to IDLE, advances `ptr` past `gnt_idx`, and pulses `timeout_err` for one cycle.
  - A transfer in the same cycle wins: the counter clears and there is no timeout.
- `PPA_TIMEOUT_EN` undefined: no counter is built, `timeout_err` is tied to 0, and a grant is held indefinitely.

## Structure
- Shared package `ppa_pkg` holds:
  - the state enum (`PPA_IDLE`, `PPA_BUSY`);
  - a function computing the index width from NUM_REQ;
  - the default TIMEOUT constant.
- One sub-module, `rr_pick`: a combinational rotate-priority picker. Inputs are the request vector and `ptr`; outputs are the index and `found`. It is reusable by other NoC arbiters.

## Test plan
- **Single burst:** req 2 sends 3 beats (last on the 3rd) with `tgt_ready`=1 → `gnt`=0100 one cycle after valid. `tgt_data` carries the 3 words on consecutive cycles. IDLE follows, and `ptr` becomes 3.
- **Fairness:** all 4 requesters continuously valid with single-beat bursts → grant order 0,1,2,3,0. Each grant is separated by one IDLE cycle.
- **No interleave:** req 1 is mid-burst and req 0 raises valid → req 0 is not granted until req 1's last beat plus one IDLE cycle. `req_ready[0]` stays 0 throughout.
- **Backpressure:** `tgt_ready` held low 5 cycles mid-burst → no beat is lost or duplicated and data stays stable while stalled. This is checked with a scoreboard.
- **Reset mid-burst:** `rst` pulsed during beat 2 of 4 → all outputs are 0 on the next cycle. A fresh request is granted with requester 0 priority.
- **Timeout (`PPA_TIMEOUT_EN`, TIMEOUT=8):** grant held with `tgt_ready`=0 → `timeout_err` pulses after 8 stall cycles and `gnt` clears. The next requester in order is granted after one IDLE cycle.
